vrp_data_ram_rsp_dmx: RTL and testbench
=======================================

VRP_DATA_RAM_RSP_DMX -- requirements
Module: vrp_data_ram_rsp_dmx

Interface
REQ-001 Parameters SHALL be: ENTRY_NUM, default L1D_MSHR_ENTRY_NUM, number of MSHR response ports; ID_WIDTH, default L1D_MSHR_ID_WIDTH, MSHR id width; ADDR_WIDTH, default 8, RAM index width; DATA_WIDTH, default 128, RAM data width; RD_LAT, default 2, RAM read latency in cycles, legal range >=1; RSP_DEPTH, default 4, response FIFO depth, legal range >=1.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 in_vld  input  1  arbitrated data-RAM request valid.
REQ-005 in_rdy  output  1  request accepted when in_vld & in_rdy.
REQ-006 in_wr  input  1  1 = write request, 0 = read request.
REQ-007 in_mshr_id  input  ID_WIDTH  requesting MSHR entry.
REQ-008 in_addr  input  ADDR_WIDTH  RAM index.
REQ-009 in_wdata  input  DATA_WIDTH  write data.
REQ-010 ram_en / ram_wr  output  1 / 1  RAM access strobe / write enable.
REQ-011 ram_addr / ram_wdata  output  ADDR_WIDTH / DATA_WIDTH  RAM index / write data.
REQ-012 ram_rdata  input  DATA_WIDTH  RAM read data, valid exactly RD_LAT cycles after a read strobe.
REQ-013 v_rsp_vld  output  ENTRY_NUM  per-MSHR read-response valid, at most one bit set.
REQ-014 v_rsp_rdy  input  ENTRY_NUM  per-MSHR read-response ready.
REQ-015 rsp_data / rsp_mshr_id  output  DATA_WIDTH / ID_WIDTH  shared response payload and owner id.

Function
REQ-016 The block SHALL keep a read-occupancy counter occ, width $clog2(RSP_DEPTH+1), equal to reads in flight in the RAM plus entries held in the response FIFO.
REQ-017 in_rdy SHALL equal !rst & (in_wr | (occ < RSP_DEPTH)); a pop in the current cycle does not raise in_rdy until the next cycle. Writes are therefore never back-pressured.
REQ-018 ram_en SHALL equal in_vld & in_rdy combinationally; ram_wr = in_wr; ram_addr = in_addr; ram_wdata = in_wdata, in the same cycle, with no register stage.
REQ-019 Writes SHALL produce no response and SHALL NOT change occ.
REQ-020 An accepted read SHALL enter a RD_LAT-stage tag pipeline holding {valid, mshr_id}; the pipeline advances every cycle unconditionally.
REQ-021 When a tag exits the pipeline, {mshr_id, ram_rdata} SHALL be pushed into the FIFO that same cycle. By construction of occ, space is guaranteed; an overflow SHALL fire an assertion.
REQ-022 The FIFO SHALL be a circular buffer of RSP_DEPTH entries; read and write pointers wrap modulo RSP_DEPTH, and full/empty are derived from a count.
REQ-023 While the FIFO is non-empty, v_rsp_vld SHALL be one-hot at bit head.mshr_id, with rsp_data = head.data and rsp_mshr_id = head.mshr_id.
REQ-024 While the FIFO is empty, v_rsp_vld, rsp_data and rsp_mshr_id SHALL all be 0.
REQ-025 The head SHALL be popped when v_rsp_rdy[head.mshr_id] is 1; all other v_rsp_rdy bits are ignored.
REQ-026 Payload SHALL hold stable while v_rsp_vld is set and not yet popped.
REQ-027 occ SHALL increment on read accept, decrement on pop, and stay unchanged when both occur in one cycle.
REQ-028 Responses SHALL return in read-acceptance order, regardless of mshr_id.
REQ-029 A push and a pop in the same cycle SHALL both take effect, including when the FIFO is empty (a pass-through is not required: the push becomes the head next cycle).
REQ-030 Minimum latency SHALL be RD_LAT+1 cycles: a read accepted in cycle T shows v_rsp_vld in cycle T+RD_LAT+1.
REQ-031 Sustained throughput SHALL be one read per cycle when RSP_DEPTH >= RD_LAT+1 and the consumer is always ready.
REQ-032 Assertions SHALL flag in_mshr_id >= ENTRY_NUM on accept, and illegal values of RD_LAT or RSP_DEPTH at elaboration.

Reset
REQ-033 While rst=1: in_rdy=0, ram_en=0, v_rsp_vld=0, rsp_data=0, rsp_mshr_id=0.
REQ-034 A clock edge with rst=1 SHALL clear occ, the FIFO pointers and count, and all tag-pipeline valids.
REQ-035 Reset applied mid-operation SHALL discard in-flight reads and queued responses; ram_rdata arriving for discarded reads SHALL be ignored.

Verification
REQ-036 RD_LAT=2: single read id=5, addr=0x10 at T, consumer ready -> ram_en at T; v_rsp_vld=0x20 at T+3 with the RAM data; pop at T+3; occ back to 0 at T+4.
REQ-037 RSP_DEPTH=4, all v_rsp_rdy=0: 6 back-to-back reads -> 4 accepted, in_rdy=0 from the 5th; a write presented while stalled is accepted immediately.
REQ-038 Reads with ids 3,1,3 and only v_rsp_rdy[1]=1 -> head id 3 stalls and nothing pops; raising v_rsp_rdy[3] drains responses in order 3,1,3.
REQ-039 Continuous reads with RSP_DEPTH=4, RD_LAT=2 and the consumer always ready -> 1 response/cycle, pointers wrap past 3->0, no overflow assertion.
REQ-040 rst pulsed with 2 reads in flight and 1 queued -> cycle after reset: v_rsp_vld=0, occ=0, late ram_rdata produces no response, new reads behave as in REQ-036.

Source files
------------

// File: rtl/vrp_data_ram_rsp_dmx.sv
// Data-RAM request front end plus read-response demux: forwards arbitrated requests to the RAM,
// tracks read tags through the RAM latency, queues returns and presents them to the owning MSHR.
`ifndef L1D_MSHR_ENTRY_NUM
`define L1D_MSHR_ENTRY_NUM 8
`endif
`ifndef L1D_MSHR_ID_WIDTH
`define L1D_MSHR_ID_WIDTH 3
`endif

module vrp_data_ram_rsp_dmx #(
    parameter int ENTRY_NUM  = `L1D_MSHR_ENTRY_NUM,
    parameter int ID_WIDTH   = `L1D_MSHR_ID_WIDTH,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 128,
    parameter int RD_LAT     = 2,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic                  in_wr,
    input  logic [ID_WIDTH-1:0]   in_mshr_id,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_wdata,
    output logic                  ram_en,
    output logic                  ram_wr,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [ENTRY_NUM-1:0]  v_rsp_vld,
    input  logic [ENTRY_NUM-1:0]  v_rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [ID_WIDTH-1:0]   rsp_mshr_id
);

    localparam int OCC_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    if (RD_LAT < 1 || RSP_DEPTH < 1 || ENTRY_NUM < 1) begin : g_bad_param
        $error("vrp_data_ram_rsp_dmx: RD_LAT and RSP_DEPTH must be >= 1");
    end

    logic [OCC_W-1:0]                 occ_q, occ_d;
    logic [RD_LAT-1:0]                tag_vld_q;
    logic [RD_LAT-1:0][ID_WIDTH-1:0]  tag_id_q;
    logic [ID_WIDTH-1:0]              fifo_id_q   [RSP_DEPTH];
    logic [DATA_WIDTH-1:0]            fifo_data_q [RSP_DEPTH];
    logic [PTR_W-1:0]                 wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]                 cnt_q, cnt_d;

    logic                  acc, rd_acc, push, pop, empty, full;
    logic [ID_WIDTH-1:0]   head_id;
    logic [DATA_WIDTH-1:0] head_data;
    logic [ENTRY_NUM-1:0]  head_oh;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // occ counts in-flight plus queued reads, so every tag leaving the pipe has a FIFO slot.
    assign in_rdy    = !rst && (in_wr || (occ_q < OCC_W'(RSP_DEPTH)));
    assign acc       = in_vld && in_rdy;
    assign rd_acc    = acc && !in_wr;

    assign ram_en    = acc;
    assign ram_wr    = in_wr;
    assign ram_addr  = in_addr;
    assign ram_wdata = in_wdata;

    assign push      = tag_vld_q[RD_LAT-1];
    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == OCC_W'(RSP_DEPTH));
    assign head_id   = fifo_id_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];

    always_comb begin
        head_oh = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            head_oh[i] = (head_id == ID_WIDTH'(i));
        end
    end

    // Only the ready bit of the head's owner can pop it.
    assign pop         = !rst && !empty && |(head_oh & v_rsp_rdy);
    assign v_rsp_vld   = (rst || empty) ? '0 : head_oh;
    assign rsp_data    = (rst || empty) ? '0 : head_data;
    assign rsp_mshr_id = (rst || empty) ? '0 : head_id;

    always_comb begin
        occ_d = occ_q;
        if (rd_acc && !pop)      occ_d = occ_q + OCC_W'(1);
        else if (!rd_acc && pop) occ_d = occ_q - OCC_W'(1);
        cnt_d = cnt_q;
        if (push && !pop)        cnt_d = cnt_q + OCC_W'(1);
        else if (!push && pop)   cnt_d = cnt_q - OCC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q     <= '0;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            tag_vld_q <= '0;
        end else begin
            occ_q        <= occ_d;
            cnt_q        <= cnt_d;
            tag_vld_q[0] <= rd_acc;
            for (int i = 1; i < RD_LAT; i++) tag_vld_q[i] <= tag_vld_q[i-1];
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end

    // Payload storage needs no reset; validity lives in the tag valids and the count.
    always_ff @(posedge clk) begin
        tag_id_q[0] <= in_mshr_id;
        for (int i = 1; i < RD_LAT; i++) tag_id_q[i] <= tag_id_q[i-1];
        if (push) begin
            fifo_id_q[wr_ptr_q]   <= tag_id_q[RD_LAT-1];
            fifo_data_q[wr_ptr_q] <= ram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full));
            assert (!(acc && (32'(in_mshr_id) >= ENTRY_NUM)));
        end
    end

endmodule

// File: tb/tb_vrp_data_ram_rsp_dmx.sv
// Randomized bench for vrp_data_ram_rsp_dmx: a RAM model plus a queue-based reference of
// outstanding reads (ordered, each visible RD_LAT+1 cycles after acceptance).
module tb_vrp_data_ram_rsp_dmx;

    localparam int EN = 8;
    localparam int IW = 3;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int RL = 2;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_vld, in_rdy, in_wr;
    logic [IW-1:0] in_mshr_id;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_wdata;
    logic          ram_en, ram_wr;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic [EN-1:0] v_rsp_vld, v_rsp_rdy;
    logic [DW-1:0] rsp_data;
    logic [IW-1:0] rsp_mshr_id;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    vrp_data_ram_rsp_dmx #(
        .ENTRY_NUM(EN), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .RD_LAT(RL), .RSP_DEPTH(RD)
    ) dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_wr(in_wr), .in_mshr_id(in_mshr_id),
        .in_addr(in_addr), .in_wdata(in_wdata),
        .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .v_rsp_vld(v_rsp_vld), .v_rsp_rdy(v_rsp_rdy),
        .rsp_data(rsp_data), .rsp_mshr_id(rsp_mshr_id)
    );

    // RAM model: read data appears RL cycles after the strobe; idle slots carry junk.
    logic [DW-1:0] mem   [256];
    logic [DW-1:0] rpipe [RL];
    always @(posedge clk) begin
        if (ram_en && ram_wr) mem[ram_addr] <= ram_wdata;
        rpipe[0] <= (ram_en && !ram_wr) ? mem[ram_addr] : DW'($urandom);
        for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
    end
    assign ram_rdata = rpipe[RL-1];

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] d;
        int            rc;
    } ent_t;
    ent_t q[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    task automatic drv(input logic v, input logic w, input logic [IW-1:0] id,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
        in_vld = v; in_wr = w; in_mshr_id = id; in_addr = a; in_wdata = d;
    endtask

    // One cycle: check outputs at the falling edge against the model, then advance.
    task automatic step();
        logic          hv, erdy, eacc, pop;
        logic [EN-1:0] ev;
        logic [DW-1:0] ed;
        logic [IW-1:0] eid;
        @(negedge clk);
        hv   = !rst && (q.size() > 0) && (q[0].rc <= cyc);
        ev   = hv ? (EN'(1) << q[0].id) : '0;
        ed   = hv ? q[0].d : '0;
        eid  = hv ? q[0].id : '0;
        erdy = !rst && (in_wr || (q.size() < RD));
        eacc = in_vld && erdy;
        chk("in_rdy", 64'(in_rdy), 64'(erdy));
        chk("ram_en", 64'(ram_en), 64'(eacc));
        if (eacc) begin
            chk("ram_addr", 64'(ram_addr), 64'(in_addr));
            chk("ram_wr", 64'(ram_wr), 64'(in_wr));
            if (in_wr) chk("ram_wdata", 64'(ram_wdata), 64'(in_wdata));
        end
        chk("v_rsp_vld", 64'(v_rsp_vld), 64'(ev));
        chk("rsp_data", 64'(rsp_data), 64'(ed));
        chk("rsp_mshr_id", 64'(rsp_mshr_id), 64'(eid));
        pop = hv && v_rsp_rdy[q[0].id];
        if (pop) void'(q.pop_front());
        if (eacc && !in_wr) q.push_back('{id: in_mshr_id, d: mem[in_addr], rc: cyc + RL + 1});
        if (rst) q.delete();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        v_rsp_rdy = '0;
        drv(1'b1, 1'b0, 3'd0, 8'h00, '0);
        repeat (3) step();
        rst = 1'b0;

        // Populate the RAM through the DUT; writes are never back-pressured.
        for (int a = 0; a < 256; a++) begin
            drv(1'b1, 1'b1, IW'($urandom), AW'(a), DW'($urandom));
            step();
        end

        // Single read, id 5, addr 0x10, consumer ready.
        v_rsp_rdy = '1;
        drv(1'b1, 1'b0, 3'd5, 8'h10, '0); step();
        drv(1'b0, 1'b0, 3'd0, 8'h00, '0); repeat (5) step();

        // Stalled consumer: four reads fit, then a write still gets through.
        v_rsp_rdy = '0;
        for (int i = 0; i < 6; i++) begin
            drv(1'b1, 1'b0, IW'(i), AW'(i + 32), '0); step();
        end
        drv(1'b1, 1'b1, 3'd0, 8'h20, DW'($urandom)); step();
        drv(1'b0, 1'b0, 3'd0, 8'h00, '0); repeat (4) step();
        v_rsp_rdy = '1; repeat (8) step();

        // Head-of-line blocking: ids 3,1,3 with only owner 1 ready.
        v_rsp_rdy = '0;
        drv(1'b1, 1'b0, 3'd3, 8'h40, '0); step();
        drv(1'b1, 1'b0, 3'd1, 8'h41, '0); step();
        drv(1'b1, 1'b0, 3'd3, 8'h42, '0); step();
        drv(1'b0, 1'b0, 3'd0, 8'h00, '0);
        v_rsp_rdy = 8'h02; repeat (6) step();
        v_rsp_rdy = 8'h0A; repeat (6) step();

        // Streaming reads at full rate, pointers wrap many times.
        v_rsp_rdy = '1;
        for (int i = 0; i < 40; i++) begin
            drv(1'b1, 1'b0, IW'($urandom), AW'($urandom), '0); step();
        end
        drv(1'b0, 1'b0, 3'd0, 8'h00, '0); repeat (4) step();

        // Reset with one response queued and two reads in flight.
        v_rsp_rdy = '0;
        drv(1'b1, 1'b0, 3'd2, 8'h50, '0); step();
        drv(1'b0, 1'b0, 3'd0, 8'h00, '0); step();
        drv(1'b1, 1'b0, 3'd4, 8'h51, '0); step();
        drv(1'b1, 1'b0, 3'd6, 8'h52, '0); step();
        drv(1'b0, 1'b0, 3'd0, 8'h00, '0);
        rst = 1'b1; step();
        rst = 1'b0;
        v_rsp_rdy = '1; repeat (4) step();
        drv(1'b1, 1'b0, 3'd5, 8'h10, '0); step();
        drv(1'b0, 1'b0, 3'd0, 8'h00, '0); repeat (5) step();

        // Random traffic with random consumer readiness and rare resets.
        for (int i = 0; i < 3000; i++) begin
            drv(($urandom_range(9) < 7), ($urandom_range(9) < 3), IW'($urandom),
                AW'($urandom), DW'($urandom));
            v_rsp_rdy = EN'($urandom);
            if ($urandom_range(9) < 2) v_rsp_rdy = '1;
            rst = ($urandom_range(499) == 0);
            step();
        end
        rst = 1'b0;
        drv(1'b0, 1'b0, 3'd0, 8'h00, '0);
        v_rsp_rdy = '1; repeat (10) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
